// File: rtl/spi_req_arbiter.sv
// Shares one SPI engine between the config-load and DAC-waveform requesters.
// Pending requests are latched, granted one at a time, and each completion is routed back to its owner.
module spi_req_arbiter #(
  parameter int unsigned MAX_DAC_BURST = 4,
  parameter int unsigned TIMEOUT_W     = 16,
  parameter int unsigned TIMEOUT       = 40000
) (
  input  logic clk,
  input  logic rst,
  input  logic req_cfg,
  input  logic req_dac,
  input  logic spi_done,
  input  logic clr_err,
  output logic trig_cfg,
  output logic trig_dac,
  output logic done_cfg,
  output logic done_dac,
  output logic busy,
  output logic owner_dac,
  output logic err_timeout,
  output logic err_overrun
);

  localparam int unsigned BURST_W = $clog2(MAX_DAC_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 pend_cfg_q, pend_cfg_d;
  logic                 pend_dac_q, pend_dac_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic                 owner_q, owner_d;
  logic                 trig_cfg_q, trig_cfg_d;
  logic                 trig_dac_q, trig_dac_d;
  logic                 done_cfg_q, done_cfg_d;
  logic                 done_dac_q, done_dac_d;
  logic                 busy_q, busy_d;
  logic                 err_to_q, err_to_d;
  logic                 err_ov_q, err_ov_d;
  logic                 grant_cfg, grant_dac, set_to, set_ov;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pend_cfg_q <= 1'b0;
      pend_dac_q <= 1'b0;
      burst_q    <= '0;
      timer_q    <= '0;
      owner_q    <= 1'b0;
      trig_cfg_q <= 1'b0;
      trig_dac_q <= 1'b0;
      done_cfg_q <= 1'b0;
      done_dac_q <= 1'b0;
      busy_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ov_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_cfg_q <= pend_cfg_d;
      pend_dac_q <= pend_dac_d;
      burst_q    <= burst_d;
      timer_q    <= timer_d;
      owner_q    <= owner_d;
      trig_cfg_q <= trig_cfg_d;
      trig_dac_q <= trig_dac_d;
      done_cfg_q <= done_cfg_d;
      done_dac_q <= done_dac_d;
      busy_q     <= busy_d;
      err_to_q   <= err_to_d;
      err_ov_q   <= err_ov_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    owner_d    = owner_q;
    burst_d    = pend_cfg_q ? burst_q : '0;
    grant_cfg  = 1'b0;
    grant_dac  = 1'b0;
    trig_cfg_d = 1'b0;
    trig_dac_d = 1'b0;
    done_cfg_d = 1'b0;
    done_dac_d = 1'b0;
    set_to     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (pend_dac_q || pend_cfg_q) begin
          state_d = S_ISSUE;
          // DAC keeps priority until a waiting cfg request has been passed over MAX_DAC_BURST times
          if (pend_dac_q && !(pend_cfg_q && burst_q == BURST_W'(MAX_DAC_BURST))) begin
            grant_dac  = 1'b1;
            owner_d    = 1'b1;
            trig_dac_d = 1'b1;
            if (pend_cfg_q) burst_d = burst_q + BURST_W'(1);
          end else begin
            grant_cfg  = 1'b1;
            owner_d    = 1'b0;
            trig_cfg_d = 1'b1;
            burst_d    = '0;
          end
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done || timer_q == TIMEOUT_W'(TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          done_dac_d = owner_q;
          done_cfg_d = !owner_q;
          set_to     = !spi_done;
        end else begin
          timer_d = timer_q + TIMEOUT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A request coinciding with its own grant is kept as a fresh pending request
    pend_cfg_d = grant_cfg ? req_cfg : (pend_cfg_q | req_cfg);
    pend_dac_d = grant_dac ? req_dac : (pend_dac_q | req_dac);
    set_ov     = (req_cfg && pend_cfg_q && !grant_cfg) || (req_dac && pend_dac_q && !grant_dac);
    err_to_d   = set_to | (err_to_q & ~clr_err);
    err_ov_d   = set_ov | (err_ov_q & ~clr_err);
    busy_d     = (state_d != S_IDLE);
  end

  assign trig_cfg    = trig_cfg_q;
  assign trig_dac    = trig_dac_q;
  assign done_cfg    = done_cfg_q;
  assign done_dac    = done_dac_q;
  assign busy        = busy_q;
  assign owner_dac   = owner_q;
  assign err_timeout = err_to_q;
  assign err_overrun = err_ov_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter: directed scenarios plus random traffic
// compared against a transaction-level reference model.
module tb_spi_req_arbiter;

  localparam int MAXB = 4;
  localparam int TW   = 16;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1, req_cfg = 1'b0, req_dac = 1'b0, spi_done = 1'b0, clr_err = 1'b0;
  logic trig_cfg, trig_dac, done_cfg, done_dac, busy, owner_dac, err_timeout, err_overrun;

  int checks = 0;
  int errors = 0;

  // Reference model: age = -1 when idle, else cycles elapsed since the trigger cycle
  bit m_pc = 0, m_pd = 0, m_owner = 0, m_eto = 0, m_eov = 0;
  int m_burst = 0, m_age = -1;
  bit e_tc = 0, e_td = 0, e_dc = 0, e_dd = 0, e_busy = 0;

  always #5 clk = ~clk;

  spi_req_arbiter #(.MAX_DAC_BURST(MAXB), .TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_cfg(req_cfg), .req_dac(req_dac), .spi_done(spi_done),
    .clr_err(clr_err), .trig_cfg(trig_cfg), .trig_dac(trig_dac), .done_cfg(done_cfg),
    .done_dac(done_dac), .busy(busy), .owner_dac(owner_dac), .err_timeout(err_timeout),
    .err_overrun(err_overrun)
  );

  task automatic model_step();
    bit gc, gd, fin, tout;
    gc = 0; gd = 0; fin = 0; tout = 0;
    if (rst) begin
      m_pc = 0; m_pd = 0; m_owner = 0; m_eto = 0; m_eov = 0;
      m_burst = 0; m_age = -1;
      e_tc = 0; e_td = 0; e_dc = 0; e_dd = 0; e_busy = 0;
    end else begin
      if (m_age < 0) begin
        if (m_pd && !(m_pc && m_burst >= MAXB)) gd = 1;
        else if (m_pc) gc = 1;
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (spi_done) begin
        fin = 1;
      end else if (m_age == TO) begin
        fin = 1; tout = 1;
      end else begin
        m_age = m_age + 1;
      end
      e_tc = gc; e_td = gd;
      e_dc = fin && !m_owner;
      e_dd = fin && m_owner;
      if (gd && m_pc) m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
      else if (gc || !m_pc) m_burst = 0;
      if (gc || gd) begin m_age = 0; m_owner = gd; end
      if (fin) m_age = -1;
      if ((req_cfg && m_pc && !gc) || (req_dac && m_pd && !gd)) m_eov = 1;
      else if (clr_err) m_eov = 0;
      if (tout) m_eto = 1;
      else if (clr_err) m_eto = 0;
      m_pc = gc ? req_cfg : (m_pc | req_cfg);
      m_pd = gd ? req_dac : (m_pd | req_dac);
      e_busy = (m_age >= 0);
    end
  endtask

  // Apply one cycle of inputs; returns #1 after the edge that samples them
  task automatic drive(input logic r, input logic rc, input logic rd, input logic sd, input logic ce);
    rst = r; req_cfg = rc; req_dac = rd; spi_done = sd; clr_err = ce;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    logic [7:0] got;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    got = {trig_cfg, trig_dac, done_cfg, done_dac, busy, owner_dac, err_timeout, err_overrun};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want %b", got, 8'h00);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_cfg();
    logic [4:0] got, ev;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      got = {trig_cfg, trig_dac, done_cfg, done_dac, busy};
      ev  = {c == 2, 1'b0, c == 11, 1'b0, (c >= 2 && c <= 10)};
      checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL single_cfg cyc%0d: got %b want %b", c, got, ev);
      end
      drive(1'b0, c == 0, 1'b0, c == 10, 1'b0);
    end
  endtask

  task automatic test_contention();
    logic [4:0] got, ev;
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      got = {trig_cfg, trig_dac, done_cfg, done_dac, busy};
      ev  = {c == 8, c == 2, c == 13, c == 7, (c >= 2 && c <= 6) || (c >= 8 && c <= 12)};
      checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL contention cyc%0d: got %b want %b", c, got, ev);
      end
      if (c == 2 || c == 8) begin
        checks++;
        if (owner_dac !== (c == 2)) begin
          errors++;
          $display("FAIL contention_owner cyc%0d: got %b want %b", c, owner_dac, c == 2);
        end
      end
      drive(1'b0, c == 0, c == 0, c == 6 || c == 12, 1'b0);
    end
  endtask

  task automatic test_starvation();
    int last_trig = -100;
    int n_dac = 0;
    int n_cfg = 0;
    logic rd;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      rd = (c == 0);
      if (trig_dac || trig_cfg) last_trig = c;
      if (trig_cfg) n_cfg++;
      if (trig_dac && n_cfg == 0) begin
        n_dac++;
        rd = 1'b1;
      end
      drive(1'b0, c == 0, rd, c == last_trig + 2, 1'b0);
    end
    checks++;
    if (n_dac !== MAXB) begin
      errors++;
      $display("FAIL starvation_dac_grants: got %0d want %0d", n_dac, MAXB);
    end
    checks++;
    if (n_cfg !== 1) begin
      errors++;
      $display("FAIL starvation_cfg_grants: got %0d want 1", n_cfg);
    end
    checks++;
    if (err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL starvation_overrun: got %b want 0", err_overrun);
    end
  endtask

  task automatic test_timeout();
    logic [4:0] got, ev;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      got = {trig_cfg, trig_dac, done_cfg, done_dac, busy};
      ev  = {1'b0, c == 2, 1'b0, c == 11, (c >= 2 && c <= 10)};
      checks++;
      if (got !== ev || err_timeout !== (c >= 11)) begin
        errors++;
        $display("FAIL timeout cyc%0d: got %b err %b want %b err %b", c, got, err_timeout, ev, c >= 11);
      end
      drive(1'b0, 1'b0, c == 0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b want 0", err_timeout);
    end
    for (int c = 0; c <= 13; c++) begin
      checks++;
      if (done_dac !== (c == 11) || err_timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_coincident cyc%0d: done %b err %b want done %b err 0",
                 c, done_dac, err_timeout, c == 11);
      end
      drive(1'b0, 1'b0, c == 0, c == 10, 1'b0);
    end
  endtask

  task automatic test_overrun();
    int n_cfg = 0;
    do_reset();
    for (int c = 0; c <= 14; c++) begin
      if (trig_cfg) n_cfg++;
      if (c == 2 || c == 3 || c == 7) begin
        checks++;
        if ((c == 7 ? trig_cfg : err_overrun) !== (c != 2)) begin
          errors++;
          $display("FAIL overrun_step cyc%0d: trig %b ovr %b", c, trig_cfg, err_overrun);
        end
      end
      drive(1'b0, c == 1 || c == 2, c == 0, c == 5 || c == 10, 1'b0);
    end
    checks++;
    if (n_cfg !== 1 || err_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_merge: got %0d trig ovr %b want 1 trig ovr 1", n_cfg, err_overrun);
    end
    do_reset();
    n_cfg = 0;
    for (int c = 0; c <= 15; c++) begin
      if (trig_cfg) begin
        n_cfg++;
        checks++;
        if (c != 2 && c != 8) begin
          errors++;
          $display("FAIL requeue_trig_time: got cyc%0d want cyc2 or cyc8", c);
        end
      end
      drive(1'b0, c == 0 || c == 4, 1'b0, c == 6 || c == 12, 1'b0);
    end
    checks++;
    if (n_cfg !== 2 || err_overrun !== 1'b0) begin
      errors++;
      $display("FAIL requeue: got %0d trig ovr %b want 2 trig ovr 0", n_cfg, err_overrun);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [5:0] got, ev;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      got = {trig_cfg, trig_dac, done_cfg, done_dac, busy, owner_dac};
      ev  = {1'b0, c == 2, 1'b0, 1'b0, (c >= 2 && c <= 5), (c >= 2 && c <= 5)};
      checks++;
      if (got !== ev || err_timeout !== 1'b0 || err_overrun !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_wait cyc%0d: got %b want %b", c, got, ev);
      end
      drive(c == 5, 1'b0, c == 0, c == 8, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [6:0] got, ev;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 399) == 0, $urandom_range(0, 99) < 12, $urandom_range(0, 99) < 18,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 4);
      got = {trig_cfg, trig_dac, done_cfg, done_dac, busy, err_timeout, err_overrun};
      ev  = {e_tc, e_td, e_dc, e_dd, e_busy, m_eto, m_eov};
      checks++;
      if (got !== ev) begin
        errors++;
        $display("FAIL random cyc%0d: got %b want %b", c, got, ev);
      end
      if (e_busy) begin
        checks++;
        if (owner_dac !== m_owner) begin
          errors++;
          $display("FAIL random_owner cyc%0d: got %b want %b", c, owner_dac, m_owner);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_cfg();
    test_contention();
    test_starvation();
    test_timeout();
    test_overrun();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
